// File: rtl/apu_reg_bank.sv
// Shadow/active register bank behind the UART receiver: captures each UART write,
// stages it in a shadow register and loads the active bank on commit or in auto mode.
module apu_reg_bank #(
    parameter int          NUM_REGS  = 15,
    parameter logic [3:0]  CTRL_ADDR = 4'd15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              uart_addr,
    input  logic [7:0]              uart_data,
    input  logic                    uart_ready,
    output logic [8*NUM_REGS-1:0]   regs_active,
    output logic [NUM_REGS-1:0]     wr_strobe,
    output logic                    auto_commit,
    output logic [NUM_REGS-1:0]     pending,
    output logic [7:0]              wr_count
);

    // Write handshake: uart_ready is a level already synchronous to clk; address and
    // data are valid while it is high, and only its 0->1 transition is a write.
    // There is no back-pressure, so every rising edge is accepted.

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_CLEAR  = 7;

    logic                   ready_d_q, ready_d_d;
    logic [7:0]             shadow_q [NUM_REGS];
    logic [7:0]             shadow_d [NUM_REGS];
    logic [7:0]             active_q [NUM_REGS];
    logic [7:0]             active_d [NUM_REGS];
    logic [NUM_REGS-1:0]    pending_q, pending_d;
    logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
    logic                   auto_commit_q, auto_commit_d;
    logic [7:0]             wr_count_q, wr_count_d;

    logic                   wr_evt;
    logic                   is_ctrl;

    assign wr_evt  = uart_ready & ~ready_d_q;
    assign is_ctrl = (uart_addr == CTRL_ADDR);

    always_comb begin
        ready_d_d     = uart_ready;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        wr_strobe_d   = '0;
        auto_commit_d = auto_commit_q;
        wr_count_d    = wr_count_q;

        if (wr_evt) begin
            wr_count_d = wr_count_q + 8'd1;
            if (!is_ctrl) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (uart_addr == 4'(k)) begin
                        shadow_d[k] = uart_data;
                        if (auto_commit_q) begin
                            active_d[k]    = uart_data;
                            wr_strobe_d[k] = 1'b1;
                            pending_d[k]   = 1'b0;
                        end else begin
                            pending_d[k]   = 1'b1;
                        end
                    end
                end
            end else begin
                auto_commit_d = uart_data[CTRL_AUTO];
                // Clear wins over commit and is silent: channels see no strobes.
                if (uart_data[CTRL_CLEAR]) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        shadow_d[k] = '0;
                        active_d[k] = '0;
                    end
                    pending_d = '0;
                end else if (uart_data[CTRL_COMMIT]) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (pending_q[k]) begin
                            active_d[k]    = shadow_q[k];
                            wr_strobe_d[k] = 1'b1;
                        end
                    end
                    pending_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_d_q     <= 1'b1;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            pending_q     <= '0;
            wr_strobe_q   <= '0;
            auto_commit_q <= 1'b0;
            wr_count_q    <= '0;
        end else begin
            ready_d_q     <= ready_d_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            wr_strobe_q   <= wr_strobe_d;
            auto_commit_q <= auto_commit_d;
            wr_count_q    <= wr_count_d;
        end
    end

    always_comb begin
        regs_active = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_active[8*k +: 8] = active_q[k];
        end
    end

    assign wr_strobe   = wr_strobe_q;
    assign auto_commit = auto_commit_q;
    assign pending     = pending_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_apu_reg_bank.sv
// Directed bench for apu_reg_bank: hand-computed expectations checked with immediate assertions.
module tb_apu_reg_bank;

    logic           clk;
    logic           rst_n;
    logic [3:0]     uart_addr;
    logic [7:0]     uart_data;
    logic           uart_ready;
    logic [119:0]   regs_active;
    logic [14:0]    wr_strobe;
    logic           auto_commit;
    logic [14:0]    pending;
    logic [7:0]     wr_count;

    int             n_checks;
    int             n_fail;
    logic [119:0]   exp_act;
    logic [7:0]     exp_cnt;

    apu_reg_bank dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_addr   (uart_addr),
        .uart_data   (uart_data),
        .uart_ready  (uart_ready),
        .regs_active (regs_active),
        .wr_strobe   (wr_strobe),
        .auto_commit (auto_commit),
        .pending     (pending),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One UART write: ready high for one edge, low for the next; strobe checked on both.
    task automatic uart_write(input logic [3:0] a, input logic [7:0] d, input logic [14:0] exp_strobe);
        @(negedge clk);
        uart_addr  = a;
        uart_data  = d;
        uart_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        check("strobe_on_write", {105'd0, wr_strobe}, {105'd0, exp_strobe});
        @(negedge clk);
        uart_ready = 1'b0;
        @(posedge clk);
        #1;
        check("strobe_after_write", {105'd0, wr_strobe}, 120'd0);
    endtask

    task automatic quick_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        uart_addr  = a;
        uart_data  = d;
        uart_ready = 1'b1;
        @(negedge clk);
        uart_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic check_state(input string tag, input logic [14:0] exp_pend, input logic exp_auto);
        check({tag, "_active"},  regs_active, exp_act);
        check({tag, "_pending"}, {105'd0, pending}, {105'd0, exp_pend});
        check({tag, "_auto"},    {119'd0, auto_commit}, {119'd0, exp_auto});
        check({tag, "_count"},   {112'd0, wr_count}, {112'd0, exp_cnt});
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_act    = '0;
        exp_cnt    = 8'd0;
        rst_n      = 1'b0;
        uart_addr  = 4'd3;
        uart_data  = 8'h5A;
        uart_ready = 1'b1;

        // Reset with uart_ready held high through and after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 15'h0000, 1'b0);
        check("reset_strobe", {105'd0, wr_strobe}, 120'd0);
        @(negedge clk);
        uart_ready = 1'b0;
        @(posedge clk);

        uart_write(4'd3, 8'h5A, 15'h0000);
        check_state("first_write", 15'h0008, 1'b0);

        // Silent clear of the staged register
        uart_write(4'd15, 8'h80, 15'h0000);
        check_state("clear_only", 15'h0000, 1'b0);

        // Staged commit
        uart_write(4'd2,  8'h11, 15'h0000);
        uart_write(4'd2,  8'h22, 15'h0000);
        uart_write(4'd14, 8'hFF, 15'h0000);
        check_state("staged", 15'h4004, 1'b0);
        exp_act[23:16]   = 8'h22;
        exp_act[119:112] = 8'hFF;
        uart_write(4'd15, 8'h01, 15'h4004);
        check_state("commit", 15'h0000, 1'b0);

        // Auto mode, including a strobe for an unchanged value
        uart_write(4'd15, 8'h02, 15'h0000);
        check_state("auto_on", 15'h0000, 1'b1);
        exp_act[7:0] = 8'hA5;
        uart_write(4'd0, 8'hA5, 15'h0001);
        check_state("auto_write", 15'h0000, 1'b1);
        uart_write(4'd0, 8'hA5, 15'h0001);
        check_state("auto_same", 15'h0000, 1'b1);

        // Empty commit
        uart_write(4'd15, 8'h01, 15'h0000);
        check_state("empty_commit", 15'h0000, 1'b0);

        // Pending survives auto-on; commit plus mode in one byte
        uart_write(4'd5, 8'h33, 15'h0000);
        check_state("pend5", 15'h0020, 1'b0);
        uart_write(4'd15, 8'h02, 15'h0000);
        check_state("auto_keeps_pend", 15'h0020, 1'b1);
        exp_act[47:40] = 8'h33;
        uart_write(4'd15, 8'h03, 15'h0020);
        check_state("commit_and_auto", 15'h0000, 1'b1);

        // Clear precedence over commit
        uart_write(4'd15, 8'h01, 15'h0000);
        uart_write(4'd7, 8'h77, 15'h0000);
        check_state("pend7", 15'h0080, 1'b0);
        exp_act = '0;
        uart_write(4'd15, 8'h81, 15'h0000);
        check_state("clear_prec", 15'h0000, 1'b0);

        // Level hold: five cycles high is one write
        @(negedge clk);
        uart_addr  = 4'd9;
        uart_data  = 8'h99;
        uart_ready = 1'b1;
        exp_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_strobe", {105'd0, wr_strobe}, 120'd0);
        end
        check_state("hold", 15'h0200, 1'b0);
        @(negedge clk);
        uart_ready = 1'b0;

        // Count wrap after 256 writes total
        while (exp_cnt != 8'd0) quick_write(4'd15, 8'h00);
        @(posedge clk);
        #1;
        check_state("wrap", 15'h0200, 1'b0);
        uart_write(4'd15, 8'h00, 15'h0000);
        check_state("after_wrap", 15'h0200, 1'b0);

        // Reset mid-operation drops pending and needs a fresh edge
        @(negedge clk);
        rst_n      = 1'b0;
        uart_ready = 1'b1;
        uart_addr  = 4'd1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        @(posedge clk);
        #1;
        check_state("mid_reset", 15'h0000, 1'b0);
        check("mid_reset_strobe", {105'd0, wr_strobe}, 120'd0);
        @(negedge clk);
        uart_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
